// File: rtl/ifmap_pkg.sv
// ifmap_pkg: layout constants shared by the ifmap SRAM write and read stages.
// Holds the row-buffer geometry, phase encodings, rows-per-phase counts,
// the write-FSM state type and the word-address helper, so both stages
// agree on exactly one address layout.
package ifmap_pkg;

  localparam int TBITS     = 64;              // one SRAM word per beat
  localparam int TBYTE     = 8;               // bytes per beat
  localparam int WINDOW    = 4;               // output windows per row
  localparam int CH        = 4;               // channel groups per column
  localparam int ROW_COLS  = WINDOW * 3;      // 12 columns per row
  localparam int ROW_WORDS = ROW_COLS * CH;   // 48 words per row slot
  localparam int NUM_SLOTS = 3;               // circular row buffer depth
  localparam int ADDR_W    = 11;

  localparam int CH_W  = $clog2(CH);
  localparam int COL_W = $clog2(ROW_COLS);

  // Row-buffer phases driven by the scheduler
  typedef enum logic [2:0] {
    PH_IDLE         = 3'd0,
    PH_UP_PADDING   = 3'd1,
    PH_THREEROW     = 3'd2,
    PH_TWOROW       = 3'd3,
    PH_ONEROW       = 3'd4,
    PH_DOWN_PADDING = 3'd5
  } phase_e;

  // Rows fetched per refill in each phase
  localparam int ROWS_THREEROW = 3;
  localparam int ROWS_TWOROW   = 1;
  localparam int ROWS_ONEROW   = 1;
  localparam int ROWS_PADDING  = 2;

  typedef enum logic [1:0] {
    IW_IDLE  = 2'd0,
    IW_WRITE = 2'd1,
    IW_FLUSH = 2'd2,
    IW_DONE  = 2'd3
  } iw_state_e;

  // slot*ROW_WORDS + col*CH + ch, unsigned in ADDR_W bits
  function automatic logic [ADDR_W-1:0] word_addr(
    input logic [1:0]       slot,
    input logic [COL_W-1:0] col,
    input logic [CH_W-1:0]  ch
  );
    return ADDR_W'(slot) * ADDR_W'(ROW_WORDS) + ADDR_W'(col) * ADDR_W'(CH) + ADDR_W'(ch);
  endfunction

endpackage

// File: rtl/ifsram_w_if.sv
// ifsram_w_if: input beat stream plus ifmap SRAM write port.
//   isif_data/isif_valid/isif_ready : upstream beat stream
//   cen/wen/addr/din_*_ifsram       : SRAM write strobe (active-low enables)
//   row_written/row_slot            : row-complete flag and its slot
// slave = write stage, master = stream source / SRAM side.
interface ifsram_w_if
  import ifmap_pkg::*;
#(
  parameter int DW = TBITS,
  parameter int AW = ADDR_W
);
  logic [DW-1:0] isif_data;
  logic          isif_valid;
  logic          isif_ready;
  logic          cen_writes_ifsram;
  logic          wen_writes_ifsram;
  logic [AW-1:0] addr_write_ifsram;
  logic [DW-1:0] din_write_ifsram;
  logic          row_written;
  logic [1:0]    row_slot;

  modport slave (
    input  isif_data, isif_valid,
    output isif_ready, cen_writes_ifsram, wen_writes_ifsram,
           addr_write_ifsram, din_write_ifsram, row_written, row_slot
  );

  modport master (
    output isif_data, isif_valid,
    input  isif_ready, cen_writes_ifsram, wen_writes_ifsram,
           addr_write_ifsram, din_write_ifsram, row_written, row_slot
  );
endinterface

// File: rtl/ifsram_w_addrgen.sv
// ifsram_w_addrgen: ch/col/row/slot counters and word-address generation.
//   i_load/i_start_slot/i_rows : restart counters for a new command
//   i_adv                      : one beat accepted, step counters
//   o_addr/o_slot              : address/slot of the current beat
//   o_row_end                  : current beat is the last of its row
//   o_cmd_end                  : current beat is the last of the command
module ifsram_w_addrgen
  import ifmap_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [1:0]        i_start_slot,
  input  logic [1:0]        i_rows,
  input  logic              i_adv,
  output logic [ADDR_W-1:0] o_addr,
  output logic [1:0]        o_slot,
  output logic              o_row_end,
  output logic              o_cmd_end
);
  logic [CH_W-1:0]  r_ch;
  logic [COL_W-1:0] r_col;
  logic [1:0]       r_row;
  logic [1:0]       r_rows;
  logic [1:0]       r_slot;
  logic             w_col_end;

  assign w_col_end = (r_ch == CH_W'(CH - 1));
  assign o_row_end = w_col_end && (r_col == COL_W'(ROW_COLS - 1));
  assign o_cmd_end = o_row_end && (r_row == r_rows - 2'd1);
  assign o_addr    = word_addr(r_slot, r_col, r_ch);
  assign o_slot    = r_slot;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ch   <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_rows <= '0;
      r_slot <= '0;
    end else if (i_load) begin
      r_ch   <= '0;
      r_col  <= '0;
      r_row  <= '0;
      r_rows <= i_rows;
      // slot code 3 has no physical row; fold it onto slot 0
      r_slot <= (i_start_slot == 2'd3) ? 2'd0 : i_start_slot;
    end else if (i_adv) begin
      if (!w_col_end) begin
        r_ch <= r_ch + 1'b1;
      end else begin
        r_ch <= '0;
        if (!o_row_end) begin
          r_col <= r_col + 1'b1;
        end else begin
          r_col  <= '0;
          r_row  <= r_row + 2'd1;
          r_slot <= (r_slot == 2'(NUM_SLOTS - 1)) ? 2'd0 : r_slot + 2'd1;
        end
      end
    end
  end
endmodule

// File: rtl/ifsram_w.sv
// ifsram_w: ifmap SRAM write stage. Takes one load command at a time and
// writes rows_to_load rows of stream beats into the 3-slot row buffer.
//   clk/reset                  : clock, async active-low reset
//   if_write_start/rows_to_load/start_slot : load command
//   if_write_busy/if_write_done           : command status (registered)
//   bus (slave)                : beat stream in, SRAM write port out
module ifsram_w
  import ifmap_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       if_write_start,
  input  logic [1:0] rows_to_load,
  input  logic [1:0] start_slot,
  output logic       if_write_busy,
  output logic       if_write_done,
  ifsram_w_if.slave  bus
);
  iw_state_e         r_state, w_nxt;
  logic              w_load, w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_slot;
  logic              w_row_end, w_cmd_end;

  assign w_load         = (r_state == IW_IDLE) && if_write_start;
  assign bus.isif_ready = (r_state == IW_WRITE);
  assign w_acc          = bus.isif_ready && bus.isif_valid;

  ifsram_w_addrgen u_addrgen (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_load),
    .i_start_slot (start_slot),
    .i_rows       (rows_to_load),
    .i_adv        (w_acc),
    .o_addr       (w_addr),
    .o_slot       (w_slot),
    .o_row_end    (w_row_end),
    .o_cmd_end    (w_cmd_end)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IW_IDLE;
    else        r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IW_IDLE:  if (if_write_start) w_nxt = (rows_to_load == 2'd0) ? IW_DONE : IW_WRITE;
      IW_WRITE: if (w_acc && w_cmd_end) w_nxt = IW_FLUSH;
      IW_FLUSH: w_nxt = IW_DONE;   // final strobe is on the SRAM pins now
      IW_DONE:  w_nxt = IW_IDLE;
      default:  w_nxt = IW_IDLE;
    endcase
  end

  // Status and SRAM pins are all registered off the current state/beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_write_busy         <= 1'b0;
      if_write_done         <= 1'b0;
      bus.cen_writes_ifsram <= 1'b1;
      bus.wen_writes_ifsram <= 1'b1;
      bus.addr_write_ifsram <= '0;
      bus.din_write_ifsram  <= '0;
      bus.row_written       <= 1'b0;
      bus.row_slot          <= '0;
    end else begin
      if_write_busy <= (r_state != IW_IDLE);
      if_write_done <= (r_state == IW_DONE);
      if (w_acc) begin
        bus.cen_writes_ifsram <= 1'b0;
        bus.wen_writes_ifsram <= 1'b0;
        bus.addr_write_ifsram <= w_addr;
        bus.din_write_ifsram  <= bus.isif_data;
        bus.row_written       <= w_row_end;
        if (w_row_end) bus.row_slot <= w_slot;
      end else begin
        bus.cen_writes_ifsram <= 1'b1;
        bus.wen_writes_ifsram <= 1'b1;
        bus.row_written       <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ifsram_w.sv
module tb_ifsram_w;
  import ifmap_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       if_write_start;
  logic [1:0] rows_to_load, start_slot;
  logic       if_write_busy, if_write_done;

  ifsram_w_if bus ();

  ifsram_w dut (
    .clk(clk), .reset(reset), .if_write_start(if_write_start),
    .rows_to_load(rows_to_load), .start_slot(start_slot),
    .if_write_busy(if_write_busy), .if_write_done(if_write_done), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct { int a; logic [63:0] d; bit rw; int s; } exp_t;

  exp_t        exp_q[$];
  logic [63:0] beats[$];
  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_wr = 0, done_cnt = 0;
  int first_cyc, last_cyc, done_cyc;
  bit first_seen, after_pend, busy_at_done, busy_after;
  bit toggle = 0, tgl = 0, pend = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Stream source: acceptance decided at negedge, consumed after the posedge.
  initial begin
    logic [63:0] dmy;
    bus.isif_valid = 1'b0;
    bus.isif_data  = '0;
    forever begin
      @(negedge clk);
      if (pend && beats.size() > 0) dmy = beats.pop_front();
      pend = 0;
      tgl  = ~tgl;
      if (beats.size() > 0 && (!toggle || tgl)) begin
        bus.isif_valid = 1'b1;
        bus.isif_data  = beats[0];
      end else begin
        bus.isif_valid = 1'b0;
      end
      pend = bus.isif_valid && bus.isif_ready && reset;
    end
  end

  // Monitor: every SRAM strobe pops one expected write.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!bus.cen_writes_ifsram) begin
          n_wr++;
          last_cyc = cyc;
          if (!first_seen) begin first_seen = 1; first_cyc = cyc; end
          if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("addr", bus.addr_write_ifsram, e.a);
            chk("din", bus.din_write_ifsram, e.d);
            chk("wen", bus.wen_writes_ifsram, 0);
            chk("row_written", bus.row_written, e.rw);
            if (e.rw) chk("row_slot", bus.row_slot, e.s);
          end
        end else begin
          chk("rw_without_write", bus.row_written, 0);
        end
        if (if_write_done) begin
          done_cnt++; done_cyc = cyc; busy_at_done = if_write_busy; after_pend = 1;
        end else if (after_pend) begin
          busy_after = if_write_busy; after_pend = 0;
        end
      end
    end
  end

  // Reference: row r of a command lands in slot (s0+r)%3, words laid out linearly.
  task automatic load_model(input int rows, input int sl);
    int s0, s;
    logic [63:0] d;
    s0 = (sl == 3) ? 0 : sl;
    for (int r = 0; r < rows; r++) begin
      s = (s0 + r) % 3;
      for (int w = 0; w < 48; w++) begin
        d = {$urandom, $urandom};
        beats.push_back(d);
        exp_q.push_back('{a: s * 48 + w, d: d, rw: (w == 47), s: s});
      end
    end
  endtask

  task automatic run_cmd(input int rows, input int sl, input bit tg, input bit tm);
    int dc0, t0, n, wr0;
    load_model(rows, sl);
    toggle = tg; dc0 = done_cnt; wr0 = n_wr; first_seen = 0;
    @(negedge clk);
    if_write_start = 1; rows_to_load = 2'(rows); start_slot = 2'(sl);
    @(negedge clk);
    if_write_start = 0; t0 = cyc;
    if (tm) begin
      repeat (10) @(negedge clk);
      if_write_start = 1; rows_to_load = 2'd3; start_slot = 2'd1;  // must be ignored
      @(negedge clk);
      if_write_start = 0;
    end
    n = 0;
    while (done_cnt == dc0 && n < 2000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    chk("done_count", done_cnt - dc0, 1);
    chk("writes", n_wr - wr0, rows * 48);
    chk("sb_empty", exp_q.size(), 0);
    chk("beats_used", beats.size(), 0);
    chk("busy_at_done", busy_at_done, 1);
    chk("busy_after_done", busy_after, 0);
    if (tm) begin
      chk("first_write_lat", first_cyc - t0, 1);
      chk("done_lat", done_cyc - last_cyc, 2);
    end
    toggle = 0;
  endtask

  initial begin
    int dc0, t0, wr0, n;
    reset = 0; if_write_start = 0; rows_to_load = 0; start_slot = 0;
    repeat (3) @(negedge clk);
    chk("rst_cen", bus.cen_writes_ifsram, 1);
    chk("rst_wen", bus.wen_writes_ifsram, 1);
    chk("rst_addr", bus.addr_write_ifsram, 0);
    chk("rst_busy", if_write_busy, 0);
    chk("rst_ready", bus.isif_ready, 0);
    reset = 1;
    repeat (2) @(negedge clk);

    run_cmd(3, 0, 0, 1);
    run_cmd(1, 2, 0, 0);
    run_cmd(2, 2, 0, 0);
    run_cmd(3, 1, 1, 0);
    run_cmd(1, 3, 0, 0);

    // zero-row command plus a second start that lands while busy
    dc0 = done_cnt; wr0 = n_wr;
    @(negedge clk); if_write_start = 1; rows_to_load = 0; start_slot = 0;
    @(negedge clk); t0 = cyc;
    @(negedge clk); if_write_start = 0;
    repeat (10) @(negedge clk);
    chk("zero_done_count", done_cnt - dc0, 1);
    chk("zero_done_lat", done_cyc - t0, 1);
    chk("zero_writes", n_wr - wr0, 0);

    // abort by reset after 60 beats
    load_model(3, 0); wr0 = n_wr;
    @(negedge clk); if_write_start = 1; rows_to_load = 3; start_slot = 0;
    @(negedge clk); if_write_start = 0;
    n = 0;
    while (n_wr - wr0 < 60 && n < 1000) begin @(negedge clk); n++; end
    chk("abort_reached_60", (n_wr - wr0 >= 60), 1);
    @(posedge clk); #2;
    reset = 0; #1;
    chk("abort_cen", bus.cen_writes_ifsram, 1);
    chk("abort_wen", bus.wen_writes_ifsram, 1);
    chk("abort_addr", bus.addr_write_ifsram, 0);
    chk("abort_din", bus.din_write_ifsram, 0);
    chk("abort_rw", bus.row_written, 0);
    chk("abort_slot", bus.row_slot, 0);
    chk("abort_busy", if_write_busy, 0);
    chk("abort_done", if_write_done, 0);
    chk("abort_ready", bus.isif_ready, 0);
    beats.delete(); exp_q.delete(); pend = 0;
    repeat (2) @(negedge clk);
    reset = 1;
    run_cmd(1, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ifsram_w.md
Name: ifsram_w

Overview:
Input-feature SRAM write stage. It sits directly upstream of the ifmap SRAM read stage.
It accepts TBITS-wide beats from the input stream and writes them into the 3-slot circular row buffer in the ifmap SRAM. Address layout is slot*ROW_WORDS + col*CH + ch.
The scheduler issues one load command per row-buffer refill: 3 rows for THREEROW, 1 row for TWOROW/ONEROW, 2 rows for padding cases.

Parameters:
TBITS, 64, data beat width (one SRAM word)
TBYTE, 8, bytes per beat
WINDOW, 4, output windows per row; ROW_COLS = WINDOW*3 = 12 columns per row
CH, 4, channel groups per column (32 ch / 8 bytes)
ADDR_W, 11, SRAM address width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
if_write_start  in  1  one-cycle load command from scheduler
rows_to_load  in  2  rows to load (0..3), sampled with start
start_slot  in  2  first physical row slot (0..2), sampled with start
if_write_busy  out  1  high while a command is in progress
if_write_done  out  1  one-cycle pulse, command complete
isif_data  in  TBITS  stream data beat
isif_valid  in  1  stream beat valid
isif_ready  out  1  stream beat accepted when valid&ready
cen_writes_ifsram  out  1  SRAM chip enable, active-low
wen_writes_ifsram  out  1  SRAM write enable, active-low
addr_write_ifsram  out  ADDR_W  SRAM write address
din_write_ifsram  out  TBITS  SRAM write data
row_written  out  1  one-cycle pulse when a full row has been written
row_slot  out  2  slot index of the row flagged by row_written

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM to IW_IDLE; all counters 0.
  - busy, done, isif_ready, row_written = 0.
  - cen/wen = 1; addr, din, row_slot = 0.
- FSM states: IW_IDLE, IW_WRITE, IW_FLUSH, IW_DONE.
  - IW_IDLE: on if_write_start, latch rows_to_load and start_slot; clear ch/col/row counters.
    - rows_to_load == 0 -> IW_DONE.
    - rows_to_load != 0 -> IW_WRITE.
  - IW_WRITE: isif_ready = 1. Each accepted beat advances ch 0..CH-1, then col 0..ROW_COLS-1, then the row count.
    - Acceptance of the last beat of the last row -> IW_FLUSH; isif_ready drops in that same cycle's next state.
  - IW_FLUSH: last SRAM write strobe is on the outputs -> IW_DONE.
  - IW_DONE: if_write_done = 1 for exactly one cycle -> IW_IDLE.
- if_write_busy = 1 in IW_WRITE, IW_FLUSH and IW_DONE.
- if_write_start while busy is ignored; no queuing.
- Write latency: a beat accepted in cycle t drives cen=0, wen=0, addr, din in cycle t+1. All SRAM outputs are registered.
  - No accepted beat in cycle t -> cen=1, wen=1 in t+1; addr and din hold their previous values.
- Address = slot*ROW_COLS*CH + col*CH + ch, computed unsigned in ADDR_W bits. Max value 3*48-1 = 143.
- Slot wrap: slot starts at start_slot and increments mod 3 after each completed row (2 -> 0).
  - start_slot == 3 is treated as 0.
- row_written pulses in the same cycle as the SRAM strobe of the row's final beat (ch=CH-1, col=ROW_COLS-1). row_slot carries that row's slot.
- isif_valid low mid-row stalls the counters, with no write and no timeout. Gaps of any length are legal.
- isif_ready = 0 outside IW_WRITE. Beats presented then are not consumed.
- Reset asserted mid-command aborts the command immediately. No done pulse is issued, and the partially written row is discarded logically.

Decomposition:
- Shared package ifmap_pkg holds:
  - Row-buffer phase encodings: IDLE=0, UP_PADDING=1, THREEROW=2, TWOROW=3, ONEROW=4, DOWN_PADDING=5.
  - WINDOW, CH, ROW_COLS, ROW_WORDS = ROW_COLS*CH, NUM_SLOTS = 3.
  - Rows-per-phase constants.
- The read stage imports the same package, so the layouts cannot diverge.
- One sub-module: ifsram_w_addrgen (ch/col/row/slot counters plus the address multiply-add). The top level holds the FSM, handshake and output registers.

Test Plan:
- Reset, then start with rows_to_load=3, start_slot=0, valid held high:
  - 144 writes at addr 0..143, consecutive, first write 1 cycle after start+1.
  - row_written at addr 47 (slot 0), 95 (slot 1), 143 (slot 2).
  - done 2 cycles after the last write strobe; busy falls with done.
- rows_to_load=1, start_slot=2: 48 writes at addr 96..143; row_slot=2 on row_written.
- rows_to_load=2, start_slot=2: slot wrap; writes at 96..143 then 0..47; row_slot sequence 2, 0.
- rows_to_load=3, valid toggling 1/0 every cycle: 144 writes spread over ~288 cycles with no address skipped or repeated. din equals the accepted isif_data, in order.
- rows_to_load=0: no cen pulse; done one cycle after IW_IDLE exit. A second start issued while busy is ignored, giving exactly one done.
- Reset pulled low at the 60th beat: all outputs return to reset values asynchronously. A new start with rows_to_load=1, start_slot=0 writes addr 0..47 cleanly.
